symbol_sequencer: RTL and testbench

- Upstream stimulus stage for the 2-bit-input state machines in this codebase.
- Captures a packed word, such as a binary-encoded student ID, and replays it MSB-first as a stream of 2-bit symbols on `a`.
- Each symbol is held for a fixed number of clocks; `a` feeds the FSM `a` input directly.
- Supports stall, abort and continuous looping, so the FSM can be exercised on-chip without a testbench driver.

---
 rtl/symbol_sequencer_pkg.sv | 21 ++
 rtl/symbol_sequencer_dwell_timer.sv | 33 +++
 rtl/symbol_sequencer.sv | 150 +++++++++++++++
 tb/tb_symbol_sequencer.sv | 253 +++++++++++++++++++++++++
 4 files changed

// File: rtl/symbol_sequencer_pkg.sv
// Shared state encodings, symbol width and sizing helper for the symbol sequencer.
package symbol_sequencer_pkg;

   localparam int SYM_W = 2;

   typedef enum logic [1:0] {
      ST_IDLE   = 2'd0,
      ST_LOADED = 2'd1,
      ST_RUN    = 2'd2,
      ST_DONE   = 2'd3
   } state_t;

   // Ceiling log2, floored at 1 so a counter never collapses to zero width.
   function automatic int clog2(input int n);
      int r;
      r = 0;
      while ((1 << r) < n) r = r + 1;
      return (r < 1) ? 1 : r;
   endfunction

endpackage

// File: rtl/symbol_sequencer_dwell_timer.sv
// Loadable dwell down-counter; tc_o flags the final held cycle of a symbol.
// Load takes effect on the next edge; en_i low freezes the count.
module dwell_timer
   import symbol_sequencer_pkg::*;
#(
   parameter int W = 2
) (
   input  logic         clk,
   input  logic         res,
   input  logic         clr_i,
   input  logic         load_i,
   input  logic [W-1:0] val_i,
   input  logic         en_i,
   output logic         tc_o
);

   logic [W-1:0] cnt_q;

   always_ff @(posedge clk) begin
      if (!res) begin
         cnt_q <= '0;
      end else if (clr_i) begin
         cnt_q <= '0;
      end else if (load_i) begin
         cnt_q <= val_i;
      end else if (en_i && (cnt_q != '0)) begin
         cnt_q <= cnt_q - 1'b1;
      end
   end

   assign tc_o = (cnt_q == '0);

endmodule

// File: rtl/symbol_sequencer.sv
// Replays a captured word MSB-first as 2-bit symbols, each held DWELL clocks.
// First symbol one clock after start; stall freezes the stream in place.
module symbol_sequencer
   import symbol_sequencer_pkg::*;
#(
   parameter  int WIDTH = 18,
   parameter  int DWELL = 4,
   localparam int NSYM  = WIDTH / 2,
   localparam int IDX_W = clog2(NSYM)
) (
   input  logic               clk,
   input  logic               res,
   input  logic               load,
   input  logic [WIDTH-1:0]   din,
   input  logic               start,
   input  logic               loop_en,
   input  logic               stall,
   input  logic               abort,
   output logic [SYM_W-1:0]   a,
   output logic               a_valid,
   output logic               busy,
   output logic               done,
   output logic [IDX_W-1:0]   idx
);

   localparam int DW_W = clog2(DWELL);
   localparam int LAST = NSYM - 1;

   state_t             state_q;
   logic [WIDTH-1:0]   word_q;
   logic [SYM_W-1:0]   a_q;
   logic               a_valid_q;
   logic               busy_q;
   logic               done_q;
   logic [IDX_W-1:0]   idx_q;

   logic [IDX_W-1:0]   idx_d;
   logic [WIDTH-1:0]   word_shift;
   logic [SYM_W-1:0]   sym_first;
   logic [SYM_W-1:0]   sym_d;
   logic               last;
   logic               tc;
   logic               start_ok;
   logic               adv;
   logic               tmr_load;
   logic               tmr_en;

   // Word register is never shifted; the symbol is picked by index so loop and replay reuse it.
   assign last       = (idx_q == IDX_W'(LAST));
   assign idx_d      = last ? '0 : idx_q + 1'b1;
   assign word_shift = word_q << (SYM_W * idx_d);
   assign sym_d      = word_shift[WIDTH-1 -: SYM_W];
   assign sym_first  = word_q[WIDTH-1 -: SYM_W];

   always_comb begin
      start_ok = 1'b0;
      adv      = 1'b0;
      if (!abort) begin
         if (((state_q == ST_LOADED) || (state_q == ST_DONE)) && !load && start) begin
            start_ok = 1'b1;
         end
         if ((state_q == ST_RUN) && !stall && tc) begin
            adv = 1'b1;
         end
      end
   end

   assign tmr_load = start_ok || (adv && (!last || loop_en));
   assign tmr_en   = (state_q == ST_RUN) && !stall && !abort;

   dwell_timer #(
      .W (DW_W)
   ) u_dwell (
      .clk    (clk),
      .res    (res),
      .clr_i  (abort),
      .load_i (tmr_load),
      .val_i  (DW_W'(DWELL - 1)),
      .en_i   (tmr_en),
      .tc_o   (tc)
   );

   always_ff @(posedge clk) begin
      if (!res) begin
         state_q   <= ST_IDLE;
         word_q    <= '0;
         a_q       <= '0;
         a_valid_q <= 1'b0;
         busy_q    <= 1'b0;
         done_q    <= 1'b0;
         idx_q     <= '0;
      end else begin
         done_q <= 1'b0;
         if (abort) begin
            state_q   <= ST_IDLE;
            word_q    <= '0;
            a_q       <= '0;
            a_valid_q <= 1'b0;
            busy_q    <= 1'b0;
            idx_q     <= '0;
         end else begin
            case (state_q)
               ST_IDLE: begin
                  if (load) begin
                     word_q  <= din;
                     state_q <= ST_LOADED;
                  end
               end
               ST_LOADED, ST_DONE: begin
                  if (load) begin
                     word_q  <= din;
                     state_q <= ST_LOADED;
                  end else if (start) begin
                     state_q   <= ST_RUN;
                     a_q       <= sym_first;
                     a_valid_q <= 1'b1;
                     busy_q    <= 1'b1;
                     idx_q     <= '0;
                  end
               end
               ST_RUN: begin
                  if (adv) begin
                     if (!last || loop_en) begin
                        idx_q <= idx_d;
                        a_q   <= sym_d;
                     end else begin
                        state_q   <= ST_DONE;
                        a_q       <= '0;
                        a_valid_q <= 1'b0;
                        busy_q    <= 1'b0;
                        done_q    <= 1'b1;
                        idx_q     <= '0;
                     end
                  end
               end
               default: begin
                  state_q <= ST_IDLE;
               end
            endcase
         end
      end
   end

   assign a       = a_q;
   assign a_valid = a_valid_q;
   assign busy    = busy_q;
   assign done    = done_q;
   assign idx     = idx_q;

endmodule

// File: tb/tb_symbol_sequencer.sv
// Randomized and directed bench for symbol_sequencer against a position-count reference model.
module tb_symbol_sequencer;

   localparam int W = 18;
   localparam int D = 4;
   localparam int N = W / 2;

   logic          clk = 1'b0;
   logic          res;
   logic          load;
   logic [W-1:0]  din;
   logic          start;
   logic          loop_en;
   logic          stall;
   logic          abort;
   logic [1:0]    a;
   logic          a_valid;
   logic          busy;
   logic          done;
   logic [3:0]    idx;

   int checks   = 0;
   int failures = 0;

   // Reference model: mode 0 idle, 1 loaded, 2 run, 3 done; m_pos counts unstalled run cycles.
   int            m_mode = 0;
   logic [W-1:0]  m_word = '0;
   int            m_pos  = 0;
   bit            m_done = 1'b0;
   bit            g_loop = 1'b0;

   logic [1:0]    lit_sym [9] = '{2'd1, 2'd1, 2'd0, 2'd0, 2'd1, 2'd2, 2'd1, 2'd0, 2'd2};
   logic [1:0]    obs [80];

   always #5 clk = ~clk;

   symbol_sequencer #(.WIDTH(W), .DWELL(D)) dut (
      .clk     (clk),
      .res     (res),
      .load    (load),
      .din     (din),
      .start   (start),
      .loop_en (loop_en),
      .stall   (stall),
      .abort   (abort),
      .a       (a),
      .a_valid (a_valid),
      .busy    (busy),
      .done    (done),
      .idx     (idx)
   );

   task automatic chk(input string nm, input int act, input int exp);
      checks++;
      if (act != exp) begin
         failures++;
         $display("FAIL %s: got %0d expected %0d (t=%0t)", nm, act, exp, $time);
      end
   endtask

   function automatic int msym(input logic [W-1:0] w, input int k);
      logic [W-1:0] t;
      t = w >> (2 * (N - 1 - k));
      return int'(t[1:0]);
   endfunction

   task automatic model_update();
      m_done = 1'b0;
      if (!res || abort) begin
         m_mode = 0;
         m_word = '0;
         m_pos  = 0;
      end else begin
         case (m_mode)
            0: if (load) begin m_word = din; m_mode = 1; end
            1, 3: begin
               if (load) begin
                  m_word = din;
                  m_mode = 1;
               end else if (start) begin
                  m_mode = 2;
                  m_pos  = 0;
               end
            end
            default: begin
               if (!stall) begin
                  m_pos++;
                  if (m_pos == N * D) begin
                     m_pos = 0;
                     if (!loop_en) begin
                        m_mode = 3;
                        m_done = 1'b1;
                     end
                  end
               end
            end
         endcase
      end
   endtask

   task automatic compare();
      bit run;
      int k;
      run = (m_mode == 2);
      k   = m_pos / D;
      chk("a_valid", int'(a_valid), int'(run));
      chk("busy",    int'(busy),    int'(run));
      chk("done",    int'(done),    int'(m_done));
      chk("a",       int'(a),       run ? msym(m_word, k) : 0);
      chk("idx",     int'(idx),     run ? k : 0);
   endtask

   // Drive at the falling edge, let the rising edge act, then check at the next falling edge.
   task automatic step(input bit r, input bit ld, input bit st, input bit sl, input bit ab,
                       input logic [W-1:0] d);
      res = r; load = ld; start = st; stall = sl; abort = ab; din = d; loop_en = g_loop;
      @(posedge clk);
      model_update();
      @(negedge clk);
      compare();
   endtask

   task automatic idle_n(input int n);
      for (int i = 0; i < n; i++) step(1, 0, 0, 0, 0, din);
   endtask

   task automatic run_pass(input int nstall, output int done_at, output int cnt4);
      int cyc;
      int ns;
      bit s;
      cyc = 1; ns = 0; done_at = 0; cnt4 = 0;
      while (cyc < 80) begin
         obs[cyc] = a;
         if (a_valid && idx == 4'd4) cnt4++;
         if (done) begin
            done_at = cyc;
            break;
         end
         s = a_valid && (idx == 4'd4) && (ns < nstall);
         if (s) ns++;
         step(1, 0, 0, s, 0, din);
         cyc++;
      end
   endtask

   initial begin
      int dat;
      int c4;
      bit seen_done;
      res = 1'b0; load = 1'b0; start = 1'b0; stall = 1'b0; abort = 1'b0; loop_en = 1'b0; din = '0;

      step(0, 0, 0, 0, 0, '0);
      step(0, 0, 0, 0, 0, '0);
      chk("rst_a", int'(a), 0);
      chk("rst_a_valid", int'(a_valid), 0);
      chk("rst_idx", int'(idx), 0);

      // Basic replay
      step(1, 1, 0, 0, 0, 18'h14192);
      step(1, 0, 1, 0, 0, 18'h14192);
      run_pass(0, dat, c4);
      chk("basic_done_cycle", dat, 37);
      chk("basic_idx4_cycles", c4, 4);
      chk("basic_a_after_done", int'(a), 0);
      for (int k = 0; k < 9; k++) begin
         chk("basic_sym_first", int'(obs[1 + 4 * k]), int'(lit_sym[k]));
         chk("basic_sym_last",  int'(obs[4 + 4 * k]), int'(lit_sym[k]));
      end

      // Stall for three cycles while idx=4
      step(1, 1, 0, 0, 0, 18'h14192);
      step(1, 0, 1, 0, 0, 18'h14192);
      run_pass(3, dat, c4);
      chk("stall_done_cycle", dat, 40);
      chk("stall_idx4_cycles", c4, 7);

      // Continuous loop
      g_loop = 1'b1;
      step(1, 1, 0, 0, 0, 18'h14192);
      step(1, 0, 1, 0, 0, 18'h14192);
      idle_n(35);
      chk("loop_c36_idx", int'(idx), 8);
      chk("loop_c36_a", int'(a), 2);
      idle_n(1);
      chk("loop_wrap_idx", int'(idx), 0);
      chk("loop_wrap_a", int'(a), 1);
      chk("loop_wrap_valid", int'(a_valid), 1);
      seen_done = 1'b0;
      for (int i = 0; i < 60; i++) begin
         step(1, 0, 0, 0, 0, din);
         if (done) seen_done = 1'b1;
      end
      chk("loop_no_done", int'(seen_done), 0);
      g_loop = 1'b0;
      step(1, 0, 0, 0, 1, din);

      // Abort at idx=5, then a start with no load
      step(1, 1, 0, 0, 0, 18'h14192);
      step(1, 0, 1, 0, 0, 18'h14192);
      idle_n(20);
      chk("abort_pre_idx", int'(idx), 5);
      step(1, 0, 0, 0, 1, din);
      chk("abort_a", int'(a), 0);
      chk("abort_valid", int'(a_valid), 0);
      step(1, 0, 1, 0, 0, din);
      chk("abort_start_ignored", int'(a_valid), 0);
      chk("abort_start_a", int'(a), 0);

      // Synchronous reset during RUN at idx=3
      step(1, 1, 0, 0, 0, 18'h14192);
      step(1, 0, 1, 0, 0, 18'h14192);
      idle_n(12);
      chk("rstmid_pre_idx", int'(idx), 3);
      res = 1'b0;
      #1;
      chk("rstmid_before_edge_valid", int'(a_valid), 1);
      chk("rstmid_before_edge_idx", int'(idx), 3);
      step(0, 0, 0, 0, 0, din);
      chk("rstmid_after_edge_valid", int'(a_valid), 0);
      chk("rstmid_after_edge_idx", int'(idx), 0);
      step(1, 0, 0, 0, 0, din);

      // load+start together from IDLE, then replay from DONE without reload
      step(1, 1, 1, 0, 0, 18'h14192);
      chk("prec_valid", int'(a_valid), 0);
      step(1, 0, 0, 0, 0, din);
      chk("prec_valid_hold", int'(a_valid), 0);
      step(1, 0, 1, 0, 0, din);
      chk("prec_first_a", int'(a), 1);
      run_pass(0, dat, c4);
      chk("prec_done_cycle", dat, 37);
      step(1, 0, 1, 0, 0, '0);
      chk("replay_a", int'(a), 1);
      chk("replay_valid", int'(a_valid), 1);
      chk("replay_idx", int'(idx), 0);
      step(1, 0, 0, 0, 1, din);

      // Randomized traffic against the model
      for (int i = 0; i < 3000; i++) begin
         g_loop = ($urandom_range(99) < 50);
         step($urandom_range(99) > 0,
              $urandom_range(99) < 6,
              $urandom_range(99) < 15,
              $urandom_range(99) < 25,
              $urandom_range(199) < 3,
              W'($urandom));
      end

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule
